// File: rtl/conv_param_loader.sv
// conv_param_loader: assembles a byte stream of filter weights and biases into
// words and writes them into conv_mem, weight banks 0..2 then bias bank 3.
// Optional feature macro: CONV_LOADER_CHECKSUM_EN adds a trailing checksum
// byte, the CHECK state and the err_o flag (err_o is tied to 0 otherwise).
module conv_param_loader #(
    parameter int unsigned BW          = 8,
    parameter int unsigned COLUMN_LEN  = 1,
    parameter int unsigned NUM_FILTERS = 8,
    localparam int unsigned ADDR_BW    = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
    localparam int unsigned BANK_BW    = 2,
    localparam int unsigned WORD_BYTES = (COLUMN_LEN > 2) ? COLUMN_LEN : 2,
    localparam int unsigned WR_BW      = WORD_BYTES * BW
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [BW-1:0]      data_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic               wr_en_o,
    output logic [BANK_BW-1:0] wr_bank_o,
    output logic [ADDR_BW-1:0] wr_addr_o,
    output logic [WR_BW-1:0]   wr_data_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    localparam int unsigned CNT_BW = $clog2(WORD_BYTES);
    localparam logic [BANK_BW-1:0] BiasBank = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWrite,
`ifdef CONV_LOADER_CHECKSUM_EN
        StCheck,
`endif
        StDone
    } state_t;

    state_t              state_q;
    logic                ready_q;
    logic                wr_en_q;
    logic [BANK_BW-1:0]  bank_q;
    logic [ADDR_BW-1:0]  addr_q;
    logic [WR_BW-1:0]    data_q;
    logic                busy_q;
    logic                done_q;
    logic [CNT_BW-1:0]   byte_cnt_q;
`ifdef CONV_LOADER_CHECKSUM_EN
    logic [7:0]          sum_q;
    logic                err_q;
`endif

    logic byte_last;
    logic addr_last;
    logic word_last;

    // Word boundary and end-of-load detection from the current bank/address/byte position
    always_comb begin
        byte_last = 1'b0;
        if (bank_q == BiasBank) begin
            byte_last = (byte_cnt_q == CNT_BW'(1));
        end else begin
            byte_last = (byte_cnt_q == CNT_BW'(COLUMN_LEN - 1));
        end
        addr_last = (addr_q == ADDR_BW'(NUM_FILTERS - 1));
        word_last = (bank_q == BiasBank) && addr_last;
    end

    // Load sequencer: all outputs are registered here, none depend combinationally on inputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            ready_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            bank_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            byte_cnt_q <= '0;
`ifdef CONV_LOADER_CHECKSUM_EN
            sum_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q    <= StLoad;
                        ready_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        bank_q     <= '0;
                        addr_q     <= '0;
                        data_q     <= '0;
                        byte_cnt_q <= '0;
`ifdef CONV_LOADER_CHECKSUM_EN
                        sum_q      <= '0;
                        err_q      <= 1'b0;
`endif
                    end
                end
                StLoad: begin
                    if (valid_i && ready_q) begin
                        // Little-endian packing: byte k lands in bits [k*BW +: BW]
                        data_q[byte_cnt_q*BW +: BW] <= data_i;
`ifdef CONV_LOADER_CHECKSUM_EN
                        sum_q <= sum_q + 8'(data_i);
`endif
                        if (byte_last) begin
                            state_q    <= StWrite;
                            ready_q    <= 1'b0;
                            wr_en_q    <= 1'b1;
                            byte_cnt_q <= '0;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + CNT_BW'(1);
                        end
                    end
                end
                StWrite: begin
                    if (word_last) begin
`ifdef CONV_LOADER_CHECKSUM_EN
                        state_q <= StCheck;
                        ready_q <= 1'b1;
`else
                        state_q <= StDone;
                        done_q  <= 1'b1;
`endif
                    end else begin
                        state_q <= StLoad;
                        ready_q <= 1'b1;
                        // Clear so bits above a shorter word read as zero
                        data_q  <= '0;
                        if (addr_last) begin
                            addr_q <= '0;
                            bank_q <= bank_q + BANK_BW'(1);
                        end else begin
                            addr_q <= addr_q + ADDR_BW'(1);
                        end
                    end
                end
`ifdef CONV_LOADER_CHECKSUM_EN
                StCheck: begin
                    if (valid_i && ready_q) begin
                        err_q   <= (8'(data_i) != sum_q);
                        ready_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
`endif
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o   = ready_q;
    assign wr_en_o   = wr_en_q;
    assign wr_bank_o = bank_q;
    assign wr_addr_o = addr_q;
    assign wr_data_o = data_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
`ifdef CONV_LOADER_CHECKSUM_EN
    assign err_o     = err_q;
`else
    assign err_o     = 1'b0;
`endif

endmodule
